// File: rtl/line_fill_responder_if.sv
// Line-fill port between the cache (master) and the backing-memory responder (slave).
// Carries the line request, the writeback beat stream and the response beat stream.
interface line_fill_responder_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) ();

  // Line request
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-5:0] req_line;

  // Writeback beats
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;

  // Response beats (refill data or write ack)
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;
  logic              rsp_is_wr;

  // Cache side
  modport master (
    output req_valid, req_write, req_line,
    output wr_valid, wr_data,
    output rsp_ready,
    input  req_ready, wr_ready,
    input  rsp_valid, rsp_data, rsp_last, rsp_is_wr
  );

  // Memory side
  modport slave (
    input  req_valid, req_write, req_line,
    input  wr_valid, wr_data,
    input  rsp_ready,
    output req_ready, wr_ready,
    output rsp_valid, rsp_data, rsp_last, rsp_is_wr
  );

endinterface

// File: rtl/line_fill_responder.sv
// Backing-memory responder for the cache refill/writeback port.
// Serves one line request at a time: a refill streams LINE_WORDS words out after LATENCY
// cycles, a writeback takes LINE_WORDS words in and acks LATENCY cycles after the last one.
// Optional completion counters are built when LINE_FILL_STATS_EN is defined; otherwise
// stat_reads/stat_writes are tied to zero.
module line_fill_responder #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned LATENCY    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  line_fill_responder_if.slave     bus,
  output logic [15:0]              stat_reads,
  output logic [15:0]              stat_writes
);

  localparam int unsigned LINE_W  = ADDR_W - 4;
  localparam int unsigned BEAT_W  = $clog2(LINE_WORDS);
  localparam int unsigned WADDR_W = LINE_W + BEAT_W;
  localparam int unsigned DEPTH   = 1 << WADDR_W;

  localparam logic [BEAT_W-1:0] LastBeat = BEAT_W'(LINE_WORDS - 1);
  localparam logic [7:0]        LatInit  = 8'(LATENCY);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StWdata = 3'd1;
  localparam logic [2:0] StWait  = 3'd2;
  localparam logic [2:0] StRdata = 3'd3;
  localparam logic [2:0] StWack  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              write_q, write_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [BEAT_W-1:0] beat_inc;
  logic [7:0]        lat_q, lat_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              req_ready_q, req_ready_d;
  logic              mem_we;

  // Word-addressed image; deliberately not reset so contents survive a responder reset.
  logic [DATA_W-1:0] mem [DEPTH];

  assign beat_inc = beat_q + 1'b1;

  // Next-state, beat/latency bookkeeping and registered refill data
  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    write_d    = write_q;
    beat_d     = beat_q;
    lat_d      = lat_q;
    rsp_data_d = rsp_data_q;
    mem_we     = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.req_valid && req_ready_q) begin
          line_d  = bus.req_line;
          write_d = bus.req_write;
          beat_d  = '0;
          if (bus.req_write) begin
            state_d = StWdata;
          end else begin
            state_d = StWait;
            lat_d   = LatInit;
          end
        end
      end

      StWdata: begin
        if (bus.wr_valid) begin
          mem_we = 1'b1;
          beat_d = beat_inc;
          if (beat_q == LastBeat) begin
            state_d = StWait;
            lat_d   = LatInit;
          end
        end
      end

      StWait: begin
        // Leaving on the count of 1 puts the first response exactly LATENCY edges out.
        if (lat_q <= 8'd1) begin
          if (write_q) begin
            state_d = StWack;
          end else begin
            state_d    = StRdata;
            rsp_data_d = mem[{line_q, beat_q}];
          end
        end else begin
          lat_d = lat_q - 8'd1;
        end
      end

      StRdata: begin
        if (bus.rsp_ready) begin
          if (beat_q == LastBeat) begin
            state_d    = StIdle;
            beat_d     = '0;
            rsp_data_d = '0;
          end else begin
            beat_d     = beat_inc;
            rsp_data_d = mem[{line_q, beat_inc}];
          end
        end
      end

      StWack: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Registered so it stays low through reset and rises one edge after release.
    req_ready_d = (state_d == StIdle);
  end

  // Control state with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      line_q      <= '0;
      write_q     <= 1'b0;
      beat_q      <= '0;
      lat_q       <= '0;
      rsp_data_q  <= '0;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      write_q     <= write_d;
      beat_q      <= beat_d;
      lat_q       <= lat_d;
      rsp_data_q  <= rsp_data_d;
      req_ready_q <= req_ready_d;
    end
  end

  // Writeback beats commit in their accept cycle
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[{line_q, beat_q}] <= bus.wr_data;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.wr_ready  = (state_q == StWdata);
  assign bus.rsp_valid = (state_q == StRdata) || (state_q == StWack);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_last  = (state_q == StWack) || ((state_q == StRdata) && (beat_q == LastBeat));
  assign bus.rsp_is_wr = (state_q == StWack);

`ifdef LINE_FILL_STATS_EN
  logic [15:0] stat_reads_q, stat_writes_q;
  logic        read_done, write_done;

  assign read_done  = (state_q == StRdata) && bus.rsp_ready && (beat_q == LastBeat);
  assign write_done = (state_q == StWack) && bus.rsp_ready;

  // Saturating completion counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_reads_q  <= '0;
      stat_writes_q <= '0;
    end else begin
      if (read_done && (stat_reads_q != 16'hFFFF)) begin
        stat_reads_q <= stat_reads_q + 16'd1;
      end
      if (write_done && (stat_writes_q != 16'hFFFF)) begin
        stat_writes_q <= stat_writes_q + 16'd1;
      end
    end
  end

  assign stat_reads  = stat_reads_q;
  assign stat_writes = stat_writes_q;
`else
  assign stat_reads  = 16'h0000;
  assign stat_writes = 16'h0000;
`endif

endmodule

// File: tb/tb_line_fill_responder.sv
// Self-checking bench for line_fill_responder: directed scenarios plus randomized
// writeback/refill traffic checked against a word-level memory model.
module tb_line_fill_responder;

  localparam int unsigned ADDR_W     = 12;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned LAT        = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  line_fill_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  logic [15:0] stat_reads;
  logic [15:0] stat_writes;

  line_fill_responder #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .LINE_WORDS (LINE_WORDS),
    .LATENCY    (LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .stat_reads  (stat_reads),
    .stat_writes (stat_writes)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] model_mem [int];
  logic [7:0]  written_lines [$];
  int exp_reads = 0;
  int exp_writes = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input bit wr, input logic [7:0] line);
    check_eq("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_line  = line;
    tick();
    bus.req_valid = 1'b0;
    check_eq("req_ready_busy", 32'(bus.req_ready), 32'd0);
  endtask

  // Counts edges from the accept edge to the first rsp_valid
  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!bus.rsp_valid && n < int'(LAT) + 20) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(n), 32'(LAT));
  endtask

  task automatic do_write(input logic [7:0] line, input logic [31:0] w [4], input int gap);
    send_req(1'b1, line);
    for (int b = 0; b < 4; b++) begin
      if (b > 0) begin
        repeat (gap) begin
          check_eq("wr_ready_gap", 32'(bus.wr_ready), 32'd1);
          tick();
        end
      end
      bus.wr_valid = 1'b1;
      bus.wr_data  = w[b];
      check_eq("wr_ready_beat", 32'(bus.wr_ready), 32'd1);
      tick();
      bus.wr_valid = 1'b0;
      model_mem[int'(line) * 4 + b] = w[b];
    end
    written_lines.push_back(line);
    wait_rsp("wack_latency");
    repeat ($urandom_range(0, 2)) begin
      check_eq("wack_hold_valid", 32'(bus.rsp_valid), 32'd1);
      tick();
    end
    check_eq("wack_valid", 32'(bus.rsp_valid), 32'd1);
    check_eq("wack_is_wr", 32'(bus.rsp_is_wr), 32'd1);
    check_eq("wack_last", 32'(bus.rsp_last), 32'd1);
    check_eq("wack_data", bus.rsp_data, 32'd0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    exp_writes++;
    check_eq("wack_done_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("wack_done_ready", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic do_read(input logic [7:0] line, input int stall_beat, input int stall_cycles);
    send_req(1'b0, line);
    wait_rsp("refill_latency");
    for (int b = 0; b < 4; b++) begin
      check_eq("refill_valid", 32'(bus.rsp_valid), 32'd1);
      check_eq("refill_data", bus.rsp_data, model_mem[int'(line) * 4 + b]);
      check_eq("refill_last", 32'(bus.rsp_last), (b == 3) ? 32'd1 : 32'd0);
      check_eq("refill_is_wr", 32'(bus.rsp_is_wr), 32'd0);
      if (b == stall_beat) begin
        repeat (stall_cycles) begin
          tick();
          check_eq("stall_valid", 32'(bus.rsp_valid), 32'd1);
          check_eq("stall_data", bus.rsp_data, model_mem[int'(line) * 4 + b]);
        end
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
    end
    exp_reads++;
    check_eq("refill_done_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("refill_done_ready", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic check_stats(input string tag);
`ifdef LINE_FILL_STATS_EN
    check_eq({tag, "_reads"}, 32'(stat_reads), 32'(exp_reads));
    check_eq({tag, "_writes"}, 32'(stat_writes), 32'(exp_writes));
`else
    check_eq({tag, "_reads"}, 32'(stat_reads), 32'd0);
    check_eq({tag, "_writes"}, 32'(stat_writes), 32'd0);
`endif
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w [4];
    logic [7:0]  line;

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_line  = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_rsp_data", bus.rsp_data, 32'd0);
    check_eq("rst_rsp_last", 32'(bus.rsp_last), 32'd0);
    check_eq("rst_rsp_is_wr", 32'(bus.rsp_is_wr), 32'd0);
    check_eq("rst_stat_reads", 32'(stat_reads), 32'd0);
    check_eq("rst_stat_writes", 32'(stat_writes), 32'd0);
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

    // Writeback then refill of line 0x2A
    w = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    do_write(8'h2A, w, 0);
    do_read(8'h2A, -1, 0);
    // Backpressure on beat 1
    do_read(8'h2A, 1, 3);
    // Stalled writeback with 2-cycle gaps
    w = '{32'hA5A50001, 32'hA5A50002, 32'hA5A50003, 32'hA5A50004};
    do_write(8'h15, w, 2);
    do_read(8'h15, -1, 0);
    check_stats("stats_3r2w");

    // Reset mid-refill during beat 2
    send_req(1'b0, 8'h2A);
    wait_rsp("rstrd_latency");
    for (int b = 0; b < 2; b++) begin
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
    end
    check_eq("rstrd_beat2_data", bus.rsp_data, model_mem[8'h2A * 4 + 2]);
    rst_n = 1'b0;
    #1;
    check_eq("rstrd_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rstrd_rsp_data", bus.rsp_data, 32'd0);
    check_eq("rstrd_rsp_last", 32'(bus.rsp_last), 32'd0);
    check_eq("rstrd_req_ready", 32'(bus.req_ready), 32'd0);
    exp_reads = 0;
    exp_writes = 0;
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("rstrd_req_ready_after", 32'(bus.req_ready), 32'd1);
    check_stats("stats_after_rst");

    // Reset mid-writeback: accepted beats stay committed, no ack
    send_req(1'b1, 8'h2A);
    for (int b = 0; b < 2; b++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 32'hBEEF0000 + 32'(b);
      tick();
      bus.wr_valid = 1'b0;
      model_mem[8'h2A * 4 + b] = 32'hBEEF0000 + 32'(b);
    end
    rst_n = 1'b0;
    #1;
    check_eq("rstwr_wr_ready", 32'(bus.wr_ready), 32'd0);
    check_eq("rstwr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    do_read(8'h2A, -1, 0);

    // Randomized traffic
    for (int i = 0; i < 14; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        line = 8'($urandom);
        for (int b = 0; b < 4; b++) w[b] = $urandom;
        do_write(line, w, int'($urandom_range(0, 2)));
      end else begin
        line = written_lines[$urandom_range(0, written_lines.size() - 1)];
        do_read(line, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end
    end
    check_stats("stats_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
